// File: rtl/pixel_sensor_array_pkg.sv
// Shared configuration for the pixel array: geometry, code width and the
// photocurrent divisor model used by every pixel.
package PixelSensorConfig;
    localparam int PIXEL_ARRAY_HEIGHT = 4;
    localparam int PIXEL_ARRAY_WIDTH  = 4;
    localparam int PIXEL_BITS         = 8;
    localparam int MAIN_CLK_PERIOD    = 10;

    // Pixel (r,c) gains one integrator count every pixel_divisor(r,c) exposure cycles.
    function automatic int pixel_divisor(input int row, input int col);
        return 1 + ((row + col) % 4);
    endfunction
endpackage

// File: rtl/pixel_sensor_array_if.sv
// Control/data bundle between the sensor controller (master) and the pixel array (slave).
interface pixel_sensor_array_if #(
    parameter int HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
    parameter int WIDTH  = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int BITS   = PixelSensorConfig::PIXEL_BITS
);
    // No valid/ready pair: ERASE/EXPOSE/RAMP/COUNTER are levels sampled at every
    // posedge clk, READ selects a row and DATA_OUT follows it combinationally.
    logic                        RAMP;
    logic                        ERASE;
    logic                        EXPOSE;
    logic [HEIGHT-1:0]           READ;
    logic [BITS-1:0]             COUNTER;
    logic [WIDTH-1:0][BITS-1:0]  DATA_OUT;

    modport master (
        output RAMP, ERASE, EXPOSE, READ, COUNTER,
        input  DATA_OUT
    );

    modport slave (
        input  RAMP, ERASE, EXPOSE, READ, COUNTER,
        output DATA_OUT
    );
endinterface

// File: rtl/pixel_sensor_array_cell.sv
// One pixel: prescaled light integrator, single-slope comparator and code memory.
module pixel_cell
    import PixelSensorConfig::*;
#(
    parameter int ROW  = 0,
    parameter int COL  = 0,
    parameter int BITS = PIXEL_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            erase,
    input  logic            expose,
    input  logic            ramp,
    input  logic [BITS-1:0] counter,
    output logic [BITS-1:0] mem
);
    // Prescaler wraps when it reaches divisor-1.
    localparam logic [1:0] P_LAST = 2'((ROW + COL) % 4);

    logic [BITS-1:0] integ;
    logic [1:0]      presc;
    logic            done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            integ <= '0;
            presc <= 2'd0;
            mem   <= '0;
            done  <= 1'b0;
        end else if (erase) begin
            integ <= '0;
            presc <= 2'd0;
            mem   <= '0;
            done  <= 1'b0;
        end else if (expose) begin
            if (presc == P_LAST) begin
                presc <= 2'd0;
                if (integ != {BITS{1'b1}})
                    integ <= integ + BITS'(1);
            end else begin
                presc <= presc + 2'd1;
            end
        end else if (ramp && !done && (counter >= integ)) begin
            // First crossing wins; later counter values (even after a wrap) are ignored.
            mem  <= counter;
            done <= 1'b1;
        end
    end
endmodule

// File: rtl/pixel_sensor_array.sv
// Pixel array top: a grid of pixel_cell instances plus the one-hot row read mux.
module pixel_sensor_array
    import PixelSensorConfig::*;
#(
    parameter int HEIGHT = PIXEL_ARRAY_HEIGHT,
    parameter int WIDTH  = PIXEL_ARRAY_WIDTH,
    parameter int BITS   = PIXEL_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    pixel_sensor_array_if.slave  bus
);
    logic [BITS-1:0] mem [HEIGHT][WIDTH];

    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            pixel_cell #(
                .ROW  (r),
                .COL  (c),
                .BITS (BITS)
            ) u_cell (
                .clk     (clk),
                .reset   (reset),
                .erase   (bus.ERASE),
                .expose  (bus.EXPOSE),
                .ramp    (bus.RAMP),
                .counter (bus.COUNTER),
                .mem     (mem[r][c])
            );
        end
    end

    // Scan from the top row down so the lowest set READ bit ends up selected.
    always_comb begin
        bus.DATA_OUT = '0;
        for (int r = HEIGHT - 1; r >= 0; r--) begin
            if (bus.READ[r]) begin
                for (int c = 0; c < WIDTH; c++)
                    bus.DATA_OUT[c] = mem[r][c];
            end
        end
    end
endmodule

// File: tb/tb_pixel_sensor_array.sv
// Scoreboard bench for pixel_sensor_array: directed sequences plus random control traffic.
module tb_pixel_sensor_array;
    import PixelSensorConfig::*;

    localparam int H  = PIXEL_ARRAY_HEIGHT;
    localparam int W  = PIXEL_ARRAY_WIDTH;
    localparam int B  = PIXEL_BITS;
    localparam int RW = W * B;
    localparam int MAXC = (1 << B) - 1;

    // Clock / reset
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #(MAIN_CLK_PERIOD / 2) clk = ~clk;

    pixel_sensor_array_if bus ();

    pixel_sensor_array dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: exposure cycles since last clear and the latched code.
    int n_exp [H][W];
    bit lat   [H][W];
    int code  [H][W];

    // Scoreboard
    logic [RW-1:0] exp_q[$];
    string         name_q[$];
    bit            rd_pend;
    int            checks;
    int            failures;

    function automatic void model_clear();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                n_exp[r][c] = 0;
                lat[r][c]   = 1'b0;
                code[r][c]  = 0;
            end
    endfunction

    function automatic int level(input int r, input int c);
        int v;
        v = n_exp[r][c] / pixel_divisor(r, c);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [RW-1:0] model_row(input logic [H-1:0] sel);
        logic [RW-1:0] v;
        v = '0;
        for (int r = 0; r < H; r++) begin
            if (sel[r]) begin
                for (int c = 0; c < W; c++)
                    v[c*B +: B] = B'(code[r][c]);
                return v;
            end
        end
        return v;
    endfunction

    // Driver tasks: inputs change 1 time unit after the active edge.
    task automatic step(input bit er, input bit ex, input bit rp, input int cnt);
        bus.ERASE   = er;
        bus.EXPOSE  = ex;
        bus.RAMP    = rp;
        bus.COUNTER = B'(cnt);
        if (er) begin
            model_clear();
        end else if (ex) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    n_exp[r][c]++;
        end else if (rp) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    if (!lat[r][c] && cnt >= level(r, c)) begin
                        lat[r][c]  = 1'b1;
                        code[r][c] = cnt;
                    end
        end
        @(posedge clk);
        #1;
        bus.ERASE  = 1'b0;
        bus.EXPOSE = 1'b0;
        bus.RAMP   = 1'b0;
    endtask

    task automatic repeat_step(input int n, input bit er, input bit ex, input bit rp, input int cnt);
        for (int i = 0; i < n; i++)
            step(er, ex, rp, cnt);
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int v = lo; v <= hi; v++)
            step(1'b0, 1'b0, 1'b1, v);
    endtask

    task automatic issue_read(input logic [H-1:0] sel, input logic [RW-1:0] exp, input string nm);
        bus.READ = sel;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        rd_pend = 1'b1;
        @(posedge clk);
        #1;
        rd_pend  = 1'b0;
        bus.READ = '0;
    endtask

    task automatic read_model(input logic [H-1:0] sel, input string nm);
        issue_read(sel, model_row(sel), nm);
    endtask

    task automatic full_sequence();
        repeat_step(5, 1'b1, 1'b0, 1'b0, 0);
        repeat_step(255, 1'b0, 1'b1, 1'b0, 0);
        sweep(0, 255);
    endtask

    // Monitor: pops one expectation for every read the driver presents.
    always @(negedge clk) begin
        if (rd_pend) begin
            logic [RW-1:0] exp_v;
            logic [RW-1:0] act_v;
            string         nm;
            checks++;
            act_v = bus.DATA_OUT;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL read_no_expectation actual=%h", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s actual=%h expected=%h", nm, act_v, exp_v);
                end
            end
        end
    end

    initial begin
        #(MAIN_CLK_PERIOD * 200000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rd_pend     = 1'b0;
        bus.ERASE   = 1'b0;
        bus.EXPOSE  = 1'b0;
        bus.RAMP    = 1'b0;
        bus.READ    = '0;
        bus.COUNTER = '0;
        model_clear();

        // Reset for one cycle, then row 0 must be empty.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue_read(4'b0001, '0, "reset_row0");

        // Full sequence: fixed expectations from the divisor model.
        full_sequence();
        issue_read(4'b0001, 32'h3F557FFF, "full_row0");
        issue_read(4'b0010, 32'hFF3F557F, "full_row1");
        issue_read(4'b0100, 32'h7FFF3F55, "full_row2");
        issue_read(4'b1000, 32'h557FFF3F, "full_row3");
        issue_read(4'b0110, 32'hFF3F557F, "multi_hot_0110");
        issue_read(4'b1111, 32'h3F557FFF, "multi_hot_1111");
        issue_read(4'b0000, '0, "read_none");
        issue_read(4'b0001, 32'h3F557FFF, "reread_row0");

        // No exposure: everything latches 0 and ignores the later sweep.
        repeat_step(5, 1'b1, 1'b0, 1'b0, 0);
        repeat_step(3, 1'b0, 1'b0, 1'b1, 0);
        sweep(0, 255);
        for (int r = 0; r < H; r++)
            issue_read(H'(1 << r), '0, "dark_latch0");

        // Reset halfway through exposure, checked while reset is still high.
        repeat_step(5, 1'b1, 1'b0, 1'b0, 0);
        full_sequence();
        repeat_step(128, 1'b0, 1'b1, 1'b0, 0);
        reset = 1'b1;
        model_clear();
        issue_read(4'b0100, '0, "async_reset_row2");
        reset = 1'b0;
        issue_read(4'b0001, '0, "after_reset_row0");
        full_sequence();
        issue_read(4'b0010, 32'hFF3F557F, "rerun_row1");
        issue_read(4'b1000, 32'h557FFF3F, "rerun_row3");

        // ERASE together with EXPOSE: clear wins, sweep from 1 latches 1 everywhere.
        repeat_step(50, 1'b0, 1'b1, 1'b0, 0);
        repeat_step(10, 1'b1, 1'b1, 1'b0, 0);
        sweep(1, 255);
        issue_read(4'b0001, 32'h01010101, "erase_expose_row0");
        issue_read(4'b0100, 32'h01010101, "erase_expose_row2");

        // Saturation: divisor-1 pixels sit at 255 and never see a large enough counter.
        repeat_step(5, 1'b1, 1'b0, 1'b0, 0);
        repeat_step(300, 1'b0, 1'b1, 1'b0, 0);
        sweep(0, 254);
        for (int r = 0; r < H; r++)
            read_model(H'(1 << r), "saturate_model");
        issue_read(4'b0001, 32'h4B64967F & 32'hFFFFFF00, "saturate_row0");

        // EXPOSE with RAMP: integration wins, no latching.
        repeat_step(5, 1'b1, 1'b0, 1'b0, 0);
        repeat_step(40, 1'b0, 1'b1, 1'b1, 255);
        sweep(0, 255);
        read_model(4'b0001, "expose_over_ramp_row0");
        issue_read(4'b0001, 32'h0A0D1428, "expose_over_ramp_fixed");

        // Random control traffic against the model.
        for (int it = 0; it < 30; it++) begin
            int nops;
            nops = $urandom_range(5, 60);
            for (int k = 0; k < nops; k++) begin
                int op;
                op = $urandom_range(0, 9);
                if (op == 0)
                    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
                else if (op <= 4)
                    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 255));
                else if (op <= 8)
                    step(1'b0, 1'b0, 1'b1, $urandom_range(0, 255));
                else
                    step(1'b0, 1'b0, 1'b0, $urandom_range(0, 255));
            end
            for (int j = 0; j < 3; j++)
                read_model(H'($urandom_range(0, 15)), "random_read");
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
